// File: rtl/l2_cache_array_assoc_pkg.sv
// Shared types for the set-associative L2 line store.
//   l2_state_t   : per-line coherence state; L2_I marks an empty or invalid way.
//   l2_arr_fsm_t : array controller state (init sweep, then ready).
// Way and response structs depend on instance parameters, so they are declared
// inside l2_cache_array_assoc itself.
package l2_cache_array_assoc_pkg;

  typedef enum logic [1:0] {
    L2_I = 2'd0,
    L2_S = 2'd1,
    L2_E = 2'd2,
    L2_M = 2'd3
  } l2_state_t;

  typedef enum logic {
    L2_ARR_INIT  = 1'b0,
    L2_ARR_READY = 1'b1
  } l2_arr_fsm_t;

  function automatic logic l2_state_valid(input l2_state_t s);
    return s != L2_I;
  endfunction

endpackage

// File: rtl/l2_cache_array_assoc_lru_age.sv
// Per-set true-LRU age update and victim nomination (purely combinational).
// Ports:
//   i_ages       : current ages of every way in the set (a permutation of 0..NUM_WAYS-1)
//   i_valid      : per-way "state is not L2_I" mask
//   i_touch_en   : apply a touch to i_touch_way
//   i_touch_way  : way to make most-recently-used
//   o_ages       : ages after the optional touch
//   o_victim_way : lowest invalid way, otherwise the oldest way
module l2_cache_array_assoc_lru_age #(
  parameter int NUM_WAYS = 4,
  localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][WAY_BITS-1:0] i_ages,
  input  logic [NUM_WAYS-1:0]               i_valid,
  input  logic                              i_touch_en,
  input  logic [WAY_BITS-1:0]               i_touch_way,
  output logic [NUM_WAYS-1:0][WAY_BITS-1:0] o_ages,
  output logic [WAY_BITS-1:0]               o_victim_way
);

  logic [WAY_BITS-1:0] w_touch_age;
  logic                w_found_inv;

  // Only ways younger than the touched one age by one, so the set stays a
  // permutation and no age can exceed NUM_WAYS-1.
  always_comb begin
    w_touch_age = i_ages[i_touch_way];
    o_ages      = i_ages;
    if (i_touch_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_BITS'(w) == i_touch_way) begin
          o_ages[w] = '0;
        end else if (i_ages[w] < w_touch_age) begin
          o_ages[w] = i_ages[w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_found_inv  = 1'b0;
    o_victim_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_found_inv && !i_valid[w]) begin
        o_victim_way = WAY_BITS'(w);
        w_found_inv  = 1'b1;
      end
    end
    if (!w_found_inv) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (i_ages[w] == WAY_BITS'(NUM_WAYS - 1)) begin
          o_victim_way = WAY_BITS'(w);
        end
      end
    end
  end

endmodule

// File: rtl/l2_cache_array_assoc.sv
// N-way set-associative L2 line store with registered lookup and true-LRU.
// After reset it sweeps one set per cycle to L2_I / tag 0 / line 0 with ages
// 0..N-1, then stays ready until the next reset.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   init_done           : init sweep finished
//   req_*               : lookup request (index, tag) with valid/ready
//   rsp_*               : registered lookup response, valid one cycle after acceptance
//   upd_*               : write one whole way; upd_touch also makes it MRU
//
// state        | meaning
// L2_ARR_INIT  | clearing set r_cnt this cycle; lookups and updates ignored
// L2_ARR_READY | serving lookups and updates
module l2_cache_array_assoc
  import l2_cache_array_assoc_pkg::*;
#(
  parameter int NUM_WAYS   = 4,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 20,
  parameter int LINE_BITS  = 512,
  localparam int WAY_BITS  = $clog2(NUM_WAYS),
  localparam int NUM_SETS  = 2 ** INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [TAG_BITS-1:0]   req_tag,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [WAY_BITS-1:0]   rsp_way,
  output l2_state_t             rsp_state,
  output logic [LINE_BITS-1:0]  rsp_line,
  output logic [WAY_BITS-1:0]   rsp_victim_way,
  output l2_state_t             rsp_victim_state,
  output logic [TAG_BITS-1:0]   rsp_victim_tag,
  output logic [LINE_BITS-1:0]  rsp_victim_line,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic [WAY_BITS-1:0]   upd_way,
  input  l2_state_t             upd_state,
  input  logic [TAG_BITS-1:0]   upd_tag,
  input  logic [LINE_BITS-1:0]  upd_line,
  input  logic                  upd_touch
);

  typedef struct packed {
    l2_state_t            state;
    logic [TAG_BITS-1:0]  tag;
    logic [LINE_BITS-1:0] line;
  } l2_way_t;

  typedef struct packed {
    logic                 hit;
    logic [WAY_BITS-1:0]  way;
    l2_state_t            state;
    logic [LINE_BITS-1:0] line;
    logic [WAY_BITS-1:0]  victim_way;
    l2_state_t            victim_state;
    logic [TAG_BITS-1:0]  victim_tag;
    logic [LINE_BITS-1:0] victim_line;
  } l2_lookup_rsp_t;

  typedef logic [NUM_WAYS-1:0][WAY_BITS-1:0] ages_t;

  l2_way_t         r_ways [NUM_SETS][NUM_WAYS];
  ages_t           r_age  [NUM_SETS];

  l2_arr_fsm_t     r_fsm, w_fsm_nxt;
  logic [INDEX_BITS-1:0] r_cnt, w_cnt_nxt;

  logic            r_rsp_valid;
  l2_lookup_rsp_t  r_rsp, w_rsp;

  logic                w_ready;
  logic                w_req_fire;
  logic                w_hit;
  logic [WAY_BITS-1:0] w_hit_way;
  logic [NUM_WAYS-1:0] w_valid_mask;
  ages_t               w_lk_ages_nxt;
  ages_t               w_upd_ages_nxt;
  logic [WAY_BITS-1:0] w_lk_victim;
  logic                w_upd_wins_age;

  assign w_ready    = (r_fsm == L2_ARR_READY);
  assign w_req_fire = req_valid && w_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fsm <= L2_ARR_INIT;
      r_cnt <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_cnt_nxt = r_cnt;
    case (r_fsm)
      L2_ARR_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == {INDEX_BITS{1'b1}}) begin
          w_fsm_nxt = L2_ARR_READY;
        end
      end
      L2_ARR_READY: ;
      default: w_fsm_nxt = L2_ARR_INIT;
    endcase
  end

  // ---------------- lookup compare ----------------
  // Descending scan so the lowest matching way wins if several match.
  always_comb begin
    w_hit        = 1'b0;
    w_hit_way    = '0;
    w_valid_mask = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      w_valid_mask[w] = l2_state_valid(r_ways[req_index][w].state);
      if (w_valid_mask[w] && (r_ways[req_index][w].tag == req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
    end
  end

  l2_cache_array_assoc_lru_age #(.NUM_WAYS(NUM_WAYS)) u_lru_lookup (
    .i_ages       (r_age[req_index]),
    .i_valid      (w_valid_mask),
    .i_touch_en   (w_hit),
    .i_touch_way  (w_hit_way),
    .o_ages       (w_lk_ages_nxt),
    .o_victim_way (w_lk_victim)
  );

  // Victim output of this instance is meaningless: only the age update is used.
  l2_cache_array_assoc_lru_age #(.NUM_WAYS(NUM_WAYS)) u_lru_update (
    .i_ages       (r_age[upd_index]),
    .i_valid      ({NUM_WAYS{1'b1}}),
    .i_touch_en   (upd_touch),
    .i_touch_way  (upd_way),
    .o_ages       (w_upd_ages_nxt),
    .o_victim_way ()
  );

  always_comb begin
    w_rsp              = '0;
    w_rsp.hit          = w_hit;
    w_rsp.victim_way   = w_lk_victim;
    w_rsp.victim_state = r_ways[req_index][w_lk_victim].state;
    w_rsp.victim_tag   = r_ways[req_index][w_lk_victim].tag;
    w_rsp.victim_line  = r_ways[req_index][w_lk_victim].line;
    w_rsp.state        = L2_I;
    if (w_hit) begin
      w_rsp.way   = w_hit_way;
      w_rsp.state = r_ways[req_index][w_hit_way].state;
      w_rsp.line  = r_ways[req_index][w_hit_way].line;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      r_rsp_valid <= w_req_fire;
      if (w_req_fire) begin
        r_rsp <= w_rsp;
      end
    end
  end

  // ---------------- array write ----------------
  // A touching update to the set being looked up owns the age row this cycle.
  assign w_upd_wins_age = upd_valid && upd_touch && (upd_index == req_index);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (r_fsm == L2_ARR_INIT) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_ways[r_cnt][w]   <= '0;
          r_age[r_cnt][w]    <= WAY_BITS'(w);
        end
      end else begin
        if (w_req_fire && w_hit && !w_upd_wins_age) begin
          r_age[req_index] <= w_lk_ages_nxt;
        end
        if (upd_valid) begin
          r_ways[upd_index][upd_way] <= '{state: upd_state, tag: upd_tag, line: upd_line};
          if (upd_touch) begin
            r_age[upd_index] <= w_upd_ages_nxt;
          end
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign init_done        = w_ready;
  assign req_ready        = w_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_hit          = r_rsp.hit;
  assign rsp_way          = r_rsp.way;
  assign rsp_state        = r_rsp.state;
  assign rsp_line         = r_rsp.line;
  assign rsp_victim_way   = r_rsp.victim_way;
  assign rsp_victim_state = r_rsp.victim_state;
  assign rsp_victim_tag   = r_rsp.victim_tag;
  assign rsp_victim_line  = r_rsp.victim_line;

endmodule

// File: doc/l2_cache_array_assoc.md
Name: l2_cache_array_assoc

Overview:
- Parametrised N-way set-associative storage array for the L2 cache. Generalises the existing direct-mapped L2 line store.
- Holds state, tag and data per way. Performs tag compare with a registered 1-cycle response. Tracks true-LRU ages per set and nominates a victim on every lookup.
- Sits under the L2 coherence controller. The controller issues lookups, then writes lines back through the update port.
- Clears itself after reset with a one-set-per-cycle init sweep.

Parameters:
- NUM_WAYS, 4, associativity; power of two, ≥2.
- INDEX_BITS, 6, set index width; NUM_SETS = 2**INDEX_BITS.
- TAG_BITS, 20, tag width.
- LINE_BITS, 512, data bits per line.
- Derived: WAY_BITS = $clog2(NUM_WAYS).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- init_done  out  1  high once the init sweep completes.
- req_valid  in  1  lookup request.
- req_ready  out  1  lookup accepted when high.
- req_index  in  INDEX_BITS  lookup set.
- req_tag  in  TAG_BITS  lookup tag.
- rsp_valid  out  1  response valid, exactly 1 cycle after an accepted request.
- rsp_hit  out  1  tag match on a way whose state is not L2_I.
- rsp_way  out  WAY_BITS  hitting way; 0 on miss.
- rsp_state  out  l2_state_t  state of the hitting way; L2_I on miss.
- rsp_line  out  LINE_BITS  data of the hitting way; 0 on miss.
- rsp_victim_way  out  WAY_BITS  replacement candidate.
- rsp_victim_state  out  l2_state_t  victim state.
- rsp_victim_tag  out  TAG_BITS  victim tag (for writeback address).
- rsp_victim_line  out  LINE_BITS  victim data.
- upd_valid  in  1  write one way.
- upd_index  in  INDEX_BITS  set to write.
- upd_way  in  WAY_BITS  way to write.
- upd_state  in  l2_state_t  new state.
- upd_tag  in  TAG_BITS  new tag.
- upd_line  in  LINE_BITS  new data.
- upd_touch  in  1  mark the written way MRU.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on reset_n; all state changes happen only at posedge clk.
- Reset values:
  - init_done=0, req_ready=0, rsp_valid=0.
  - All rsp_* data outputs 0; rsp_state and rsp_victim_state = L2_I.
  - FSM enters INIT with sweep counter=0.
- FSM INIT:
  - Each cycle, set[counter] gets every way state=L2_I, tag=0, line=0, and age[w]=w.
  - Counter increments each cycle. After index NUM_SETS-1 is written, go to READY next cycle.
  - INIT lasts exactly NUM_SETS cycles after reset release.
  - upd_valid is ignored in INIT (illegal; bench asserts it never occurs).
- FSM READY:
  - init_done=1 and req_ready=1 permanently, until the next reset.
  - No other transitions. Reset in any state returns to INIT with counter 0, and rsp_valid=0 on the next cycle.
- Lookup:
  - Accepted when req_valid && req_ready.
  - At that edge the selected set is read and compared, and every rsp_* field is registered. rsp_valid=1 for exactly the following cycle.
  - Back-to-back requests give back-to-back responses. rsp_valid drops when no request was accepted; rsp data then holds its last value.
- Hit: at most one way matches (controller guarantee). If several match, the lowest way wins.
- Victim selection: the lowest-numbered way in state L2_I. If there is none, the way with age == NUM_WAYS-1.
- LRU:
  - Ages per set form a permutation of 0..NUM_WAYS-1.
  - Touching way w: every way with age < age[w] increments; age[w] becomes 0.
  - A lookup hit touches the hitting way. A miss does not touch.
- Update:
  - upd_valid writes the whole way at the edge, with no latency to the array.
  - upd_touch additionally touches that way.
- Simultaneous events:
  - Lookup and update in the same cycle: the response reflects pre-update contents (read-before-write). The next lookup sees the new contents.
  - Both touch the same set in the same cycle: only the update touch is applied.
  - Different sets: both touches are applied.
- Widths: ages are WAY_BITS wide. Increments never overflow because only ages below age[w] increment.

Decomposition:
- Shared package (cache.svh):
  - l2_state_t is reused unchanged (L2_I etc.).
  - Add a parametrised l2_way_t struct (state, tag, line) and an l2_lookup_rsp_t struct.
  - Add the INIT/READY enum l2_arr_fsm_t.
- Sub-module l2_lru_age: purely combinational, per set.
  - Inputs: ages, valid mask, touch enable, touch way.
  - Outputs: next ages and victim way.
  - Instantiated once for the lookup path and once for the update path.

Test Plan:
- Reset, INDEX_BITS=6: hold reset_n low 2 cycles then release.
  - Expected: init_done and req_ready rise exactly 64 cycles later.
  - Then lookup index 17 tag 0x5 -> rsp_hit=0, rsp_victim_way=0, rsp_victim_state=L2_I.
- Fill: update index 5, ways 0..3, tags 0x100..0x103, non-I state, line=tag replicated, upd_touch=1.
  - Then lookup tag 0x102 -> next cycle rsp_valid=1, rsp_hit=1, rsp_way=2, rsp_line matches.
- LRU: after the fill above (touch order 0,1,2,3), lookup index 5 tag 0x1FF -> victim_way=0.
  - Then lookup tag 0x100 (hit, way 0), then tag 0x1FF again -> victim_way=1, victim_tag=0x101.
- Invalid priority: update index 5 way 2 to state L2_I without touch.
  - Then miss lookup -> victim_way=2 regardless of ages.
- Collision: same cycle, lookup index 5 tag 0x103 plus update index 5 way 3 tag 0x200.
  - Expected: response hit=1, way=3 (old contents). Next lookup of tag 0x103 misses; tag 0x200 hits way 3.
- Reset mid-stream: drop reset_n for 1 cycle during back-to-back lookups.
  - Expected: rsp_valid=0 next cycle, init re-runs for 64 cycles. Afterwards tag 0x100 at index 5 misses.
